// File: rtl/imem_responder_if.sv
// Fetch <-> instruction-memory bus: request, response, redirect and preload.
interface imem_responder_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        busy;

    // Fetch side
    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, busy
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, busy
    );
endinterface

// File: rtl/imem_responder.sv
// Multi-cycle instruction store: one outstanding fetch, fixed latency,
// flushable, with an IDLE-only preload write port.
module imem_responder #(
    parameter int LATENCY    = 2,   // 1..7
    parameter int DEPTH_LOG2 = 10
) (
    input  logic      clk,
    input  logic      rst,
    imem_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] raddr_q, raddr_d;
    logic        err_q, err_d;

    logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

    logic                  req_ready;
    logic                  accept;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;

    // Byte addresses map to words; bits above the store size wrap.
    assign rd_idx = addr_q[DEPTH_LOG2:1];
    assign wr_idx = bus.ld_addr[DEPTH_LOG2:1];
    assign accept = bus.req_valid & req_ready;

    logic unused_ld;
    assign unused_ld = &{1'b0, bus.ld_addr[0], bus.ld_addr[15:DEPTH_LOG2+1]};

    // State, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0;
            instr_q <= 16'h0;
            raddr_q <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
        end
    end

    // Preload write; only in IDLE so it never collides with a read. Not reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && bus.ld_en && !accept)
            mem[wr_idx] <= bus.ld_data;
    end

    // Next-state: flush wins over consume/accept in the busy states
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        raddr_d = raddr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = S_RESP;
                    raddr_d = addr_q;
                    if (addr_q[0]) begin
                        instr_d = 16'h0800;   // NOP for a misaligned fetch
                        err_d   = 1'b1;
                    end else begin
                        instr_d = mem[rd_idx];
                        err_d   = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.rsp_ready) begin
                    if (accept) begin
                        addr_d  = bus.req_addr;
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: req_ready is combinational, the rest come from registers
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = !bus.ld_en && !bus.flush;
            S_RESP:  req_ready = bus.rsp_ready && !bus.flush;
            default: req_ready = 1'b0;
        endcase
        if (rst) req_ready = 1'b0;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_instr = instr_q;
    assign bus.rsp_addr  = raddr_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (LATENCY=2, DEPTH_LOG2=10).
module tb_imem_responder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    imem_responder_if bus ();

    imem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rsp_valid"}, 16'(bus.rsp_valid), 16'h0);
        chk({tag, ".rsp_instr"}, bus.rsp_instr, 16'h0);
        chk({tag, ".rsp_addr"},  bus.rsp_addr,  16'h0);
        chk({tag, ".rsp_err"},   16'(bus.rsp_err), 16'h0);
        chk({tag, ".busy"},      16'(bus.busy), 16'h0);
        chk({tag, ".req_ready"}, 16'(bus.req_ready), 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 0; bus.req_addr = 0; bus.rsp_ready = 0; bus.flush = 0;
        bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
        #2;
        chk_zero("reset");
        tick(); tick();
        rst = 1'b0;

        // Preload; req_ready must drop while ld_en is high
        bus.ld_en = 1; bus.ld_addr = 16'h0000; bus.ld_data = 16'h1234;
        #1 chk("ld_blocks_ready", 16'(bus.req_ready), 16'h0);
        tick();
        bus.ld_addr = 16'h0002; bus.ld_data = 16'hABCD;
        tick();
        bus.ld_en = 0;

        // Basic read, rsp_ready high: valid 2 edges after accept, busy 3 cycles
        bus.rsp_ready = 1; bus.req_valid = 1; bus.req_addr = 16'h0000;
        #1 chk("idle_ready", 16'(bus.req_ready), 16'h1);
        tick(); bus.req_valid = 0;
        chk("r0.c1.valid", 16'(bus.rsp_valid), 16'h0);
        chk("r0.c1.busy",  16'(bus.busy), 16'h1);
        tick();
        chk("r0.c2.valid", 16'(bus.rsp_valid), 16'h0);
        chk("r0.c2.busy",  16'(bus.busy), 16'h1);
        tick();
        chk("r0.valid", 16'(bus.rsp_valid), 16'h1);
        chk("r0.instr", bus.rsp_instr, 16'h1234);
        chk("r0.addr",  bus.rsp_addr, 16'h0000);
        chk("r0.err",   16'(bus.rsp_err), 16'h0);
        chk("r0.busy",  16'(bus.busy), 16'h1);
        tick();
        chk("r0.done.busy",  16'(bus.busy), 16'h0);
        chk("r0.done.valid", 16'(bus.rsp_valid), 16'h0);
        chk("r0.done.held",  bus.rsp_instr, 16'h1234);

        // Backpressure: hold 5 cycles, then back-to-back accept of 0x0002
        bus.rsp_ready = 0; bus.req_valid = 1; bus.req_addr = 16'h0000;
        tick(); bus.req_addr = 16'h0002;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 16'(bus.rsp_valid), 16'h1);
            chk("hold.instr", bus.rsp_instr, 16'h1234);
            chk("hold.ready", 16'(bus.req_ready), 16'h0);
            tick();
        end
        bus.rsp_ready = 1;
        #1 chk("b2b.ready", 16'(bus.req_ready), 16'h1);
        tick(); bus.req_valid = 0;
        chk("b2b.wait.valid", 16'(bus.rsp_valid), 16'h0);
        chk("b2b.wait.busy",  16'(bus.busy), 16'h1);
        tick(); tick();
        chk("b2b.valid", 16'(bus.rsp_valid), 16'h1);
        chk("b2b.instr", bus.rsp_instr, 16'hABCD);
        chk("b2b.addr",  bus.rsp_addr, 16'h0002);
        tick();

        // Misaligned fetch returns NOP with err
        bus.req_valid = 1; bus.req_addr = 16'h0003;
        tick(); bus.req_valid = 0;
        tick(); tick();
        chk("mis.valid", 16'(bus.rsp_valid), 16'h1);
        chk("mis.instr", bus.rsp_instr, 16'h0800);
        chk("mis.err",   16'(bus.rsp_err), 16'h1);
        chk("mis.addr",  bus.rsp_addr, 16'h0003);
        tick();

        // Wrap: 0x0800 aliases word 0; a preload attempted in WAIT is ignored
        bus.req_valid = 1; bus.req_addr = 16'h0800;
        tick(); bus.req_valid = 0;
        bus.ld_en = 1; bus.ld_addr = 16'h0000; bus.ld_data = 16'hFFFF;
        tick(); bus.ld_en = 0;
        tick();
        chk("wrap.valid", 16'(bus.rsp_valid), 16'h1);
        chk("wrap.instr", bus.rsp_instr, 16'h1234);
        chk("wrap.err",   16'(bus.rsp_err), 16'h0);
        chk("wrap.addr",  bus.rsp_addr, 16'h0800);
        tick();

        // Flush one cycle after accept: request vanishes
        bus.req_valid = 1; bus.req_addr = 16'h0002;
        tick(); bus.req_valid = 0; bus.flush = 1;
        #1 chk("fl.ready_low", 16'(bus.req_ready), 16'h0);
        tick(); bus.flush = 0;
        #1 chk("fl.ready_after", 16'(bus.req_ready), 16'h1);
        chk("fl.busy", 16'(bus.busy), 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fl.no_valid", 16'(bus.rsp_valid), 16'h0);
            tick();
        end

        // Flush in RESP beats a simultaneous consume + new request
        bus.rsp_ready = 0; bus.req_valid = 1; bus.req_addr = 16'h0000;
        tick(); bus.req_valid = 0;
        tick(); tick();
        chk("flr.valid", 16'(bus.rsp_valid), 16'h1);
        bus.flush = 1; bus.rsp_ready = 1; bus.req_valid = 1; bus.req_addr = 16'h0002;
        #1 chk("flr.ready_low", 16'(bus.req_ready), 16'h0);
        tick(); bus.flush = 0; bus.req_valid = 0;
        chk("flr.busy",  16'(bus.busy), 16'h0);
        chk("flr.valid_low", 16'(bus.rsp_valid), 16'h0);
        tick();
        chk("flr.still_idle", 16'(bus.busy), 16'h0);

        // Reset while in WAIT, then store retained
        bus.req_valid = 1; bus.req_addr = 16'h0002;
        tick(); bus.req_valid = 0;
        chk("rw.busy_pre", 16'(bus.busy), 16'h1);
        rst = 1'b1;
        #1 chk_zero("rst_wait");
        tick();
        rst = 1'b0;
        bus.req_valid = 1; bus.req_addr = 16'h0000;
        tick(); bus.req_valid = 0;
        tick(); tick();
        chk("post_rst.valid", 16'(bus.rsp_valid), 16'h1);
        chk("post_rst.instr", bus.rsp_instr, 16'h1234);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
